seq_shift_unit: RTL and testbench

Parametrised, multi-mode iterative shifter for the lab ALU datapath. It captures an operand and shift amount on `init`, then shifts one bit position per clock. It supports logical-left, logical-right, arithmetic-right and rotate-left. It reports completion with a one-cycle `done` pulse and holds the result until the next operation.

---
 rtl/seq_shift_unit_pkg.sv | 15 +
 rtl/seq_shift_unit_if.sv | 36 +++
 rtl/seq_shift_unit_shift_step.sv | 24 ++
 rtl/seq_shift_unit.sv | 106 ++++++++++
 tb/tb_seq_shift_unit.sv | 174 +++++++++++++++++
 5 files changed

// File: rtl/seq_shift_unit_pkg.sv
// Shared definitions for the iterative shifter: mode codes and FSM state encoding.
package seq_shift_pkg;

    localparam logic [1:0] MODE_LSL = 2'b00;
    localparam logic [1:0] MODE_LSR = 2'b01;
    localparam logic [1:0] MODE_ASR = 2'b10;
    localparam logic [1:0] MODE_ROL = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_FINISH = 2'd2
    } state_t;

endpackage : seq_shift_pkg

// File: rtl/seq_shift_unit_if.sv
// Request/result bundle for seq_shift_unit.
//
// Handshake: the requester raises init with data_in/amount/mode for one or
// more cycles while busy=0; the edge that samples init=1 in IDLE accepts the
// request. busy is high from the following cycle until the completion cycle,
// in which done pulses for exactly one cycle with out/zero valid. Requests
// presented while busy=1 are dropped, and inputs are free to change once the
// request has been accepted. out/zero hold until the next accepted request.
interface seq_shift_unit_if
    import seq_shift_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int AMT_W = $clog2(WIDTH)
);

    logic             init;
    logic [WIDTH-1:0] data_in;
    logic [AMT_W-1:0] amount;
    logic [1:0]       mode;
    logic [WIDTH-1:0] out;
    logic             done;
    logic             busy;
    logic             zero;
    state_t           dbg_state;

    modport master (
        output init, data_in, amount, mode,
        input  out, done, busy, zero, dbg_state
    );

    modport slave (
        input  init, data_in, amount, mode,
        output out, done, busy, zero, dbg_state
    );

endinterface : seq_shift_unit_if

// File: rtl/seq_shift_unit_shift_step.sv
// One single-bit shift/rotate step in the selected mode (purely combinational).
module shift_step
    import seq_shift_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] data_i,
    input  logic [1:0]       mode_i,
    output logic [WIDTH-1:0] data_o
);

    // Select the one-position move for the current mode.
    always_comb begin
        data_o = data_i;
        case (mode_i)
            MODE_LSL: data_o = {data_i[WIDTH-2:0], 1'b0};
            MODE_LSR: data_o = {1'b0, data_i[WIDTH-1:1]};
            MODE_ASR: data_o = {data_i[WIDTH-1], data_i[WIDTH-1:1]};
            MODE_ROL: data_o = {data_i[WIDTH-2:0], data_i[WIDTH-1]};
            default:  data_o = data_i;
        endcase
    end

endmodule : shift_step

// File: rtl/seq_shift_unit.sv
// Iterative multi-mode shifter: latches an operand on init, shifts one bit per
// clock for `amount` cycles, then presents a registered result with a one-cycle
// done pulse. The result register and zero flag hold until the next request.
module seq_shift_unit
    import seq_shift_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int AMT_W = $clog2(WIDTH)
) (
    input logic              clk,
    input logic              rst,
    seq_shift_unit_if.slave  bus_if
);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [AMT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       mode_q, mode_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic             done_q, done_d;
    logic             zero_q, zero_d;
    logic [WIDTH-1:0] step_data;

    shift_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .data_i (data_q),
        .mode_i (mode_q),
        .data_o (step_data)
    );

    // State, datapath and result registers; reset aborts any operation.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            data_q  <= '0;
            cnt_q   <= '0;
            mode_q  <= MODE_LSL;
            out_q   <= '0;
            done_q  <= 1'b0;
            zero_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
            out_q   <= out_d;
            done_q  <= done_d;
            zero_q  <= zero_d;
        end
    end

    // Next-state and datapath control. The result is loaded on the same edge
    // that enters FINISH, so it takes the value the data register is about to
    // hold (the fresh operand for amount=0, otherwise the final step).
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        cnt_d   = cnt_q;
        mode_d  = mode_q;
        out_d   = out_q;
        zero_d  = zero_q;
        done_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus_if.init) begin
                    data_d = bus_if.data_in;
                    mode_d = bus_if.mode;
                    cnt_d  = bus_if.amount;
                    if (bus_if.amount != '0) begin
                        state_d = ST_SHIFT;
                    end else begin
                        state_d = ST_FINISH;
                        out_d   = bus_if.data_in;
                        zero_d  = (bus_if.data_in == '0);
                        done_d  = 1'b1;
                    end
                end
            end
            ST_SHIFT: begin
                data_d = step_data;
                cnt_d  = cnt_q - 1'b1;
                if (cnt_q == {{(AMT_W-1){1'b0}}, 1'b1}) begin
                    state_d = ST_FINISH;
                    out_d   = step_data;
                    zero_d  = (step_data == '0);
                    done_d  = 1'b1;
                end
            end
            ST_FINISH: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign bus_if.out       = out_q;
    assign bus_if.done      = done_q;
    assign bus_if.zero      = zero_q;
    assign bus_if.busy      = (state_q != ST_IDLE);
    assign bus_if.dbg_state = state_q;

endmodule : seq_shift_unit

// File: tb/tb_seq_shift_unit.sv
// Directed + random bench for seq_shift_unit (WIDTH=8) with an expected-result queue.
module tb_seq_shift_unit;
  import seq_shift_pkg::*;

  localparam int W  = 8;
  localparam int AW = 3;

  logic clk = 1'b0;
  logic rst;
  int errors = 0;
  int checks = 0;
  logic [W-1:0] exp_q[$];

  seq_shift_unit_if #(.WIDTH(W), .AMT_W(AW)) bus ();

  seq_shift_unit #(.WIDTH(W), .AMT_W(AW)) dut (
    .clk    (clk),
    .rst    (rst),
    .bus_if (bus)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // reference: whole shift in one expression
  function automatic logic [W-1:0] model(input logic [W-1:0] d, input int a, input logic [1:0] m);
    logic signed [W-1:0] s;
    s = d;
    case (m)
      MODE_LSL: return d << a;
      MODE_LSR: return d >> a;
      MODE_ASR: return W'(s >>> a);
      default:  return (a == 0) ? d : ((d << a) | (d >> (W - a)));
    endcase
  endfunction

  // Called just after a negedge; the following posedge is E0.
  task automatic start_op(input logic [W-1:0] d, input int a, input logic [1:0] m, input logic [W-1:0] e);
    exp_q.push_back(e);
    bus.init    = 1'b1;
    bus.data_in = d;
    bus.amount  = AW'(a);
    bus.mode    = m;
    @(posedge clk);
    #1;
    bus.init    = 1'b0;
    bus.data_in = W'($urandom_range(0, 255));
    bus.amount  = AW'($urandom_range(0, 7));
    bus.mode    = 2'($urandom_range(0, 3));
  endtask

  // Waits for done, checks latency, busy span, result; ends one negedge after done.
  task automatic wait_done(input int a, input string tag, input bit inject);
    int k = 0;
    int busy_cnt = 0;
    bit seen = 0;
    logic [W-1:0] e;
    while (!seen && k < 40) begin
      @(negedge clk);
      k++;
      if (bus.busy) busy_cnt++;
      if (inject && k == 2) begin
        bus.init = 1'b1; bus.data_in = '1; bus.amount = 3'd1; bus.mode = MODE_ROL;
      end
      if (inject && k == 3) bus.init = 1'b0;
      if (bus.done) seen = 1;
    end
    check({tag, "_done_seen"}, 32'(seen), 32'd1);
    check({tag, "_latency"}, 32'(k), 32'(a + 1));
    check({tag, "_busy_cycles"}, 32'(busy_cnt), 32'(a + 1));
    check({tag, "_queue_nonempty"}, 32'(exp_q.size() > 0), 32'd1);
    e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
    check({tag, "_out"}, 32'(bus.out), 32'(e));
    check({tag, "_zero"}, 32'(bus.zero), 32'(e == '0));
    if (inject) begin
      bus.init = 1'b1; bus.data_in = '1; bus.amount = '0; bus.mode = MODE_LSL;
    end
    @(negedge clk);
    bus.init = 1'b0;
    check({tag, "_done_pulse"}, 32'(bus.done), 32'd0);
    check({tag, "_busy_after"}, 32'(bus.busy), 32'd0);
    check({tag, "_out_hold"}, 32'(bus.out), 32'(e));
  endtask

  initial begin
    logic [W-1:0] rd;
    int ra;
    logic [1:0] rm;

    rst = 1'b1;
    bus.init = 1'b0; bus.data_in = '0; bus.amount = '0; bus.mode = MODE_LSL;
    repeat (2) @(negedge clk);
    check("rst_busy_held", 32'(bus.busy), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("rst_out", 32'(bus.out), 32'h00);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_zero", 32'(bus.zero), 32'd1);
    check("rst_state", 32'(bus.dbg_state), 32'(ST_IDLE));

    // test 1
    start_op(8'h05, 1, MODE_LSL, 8'h0A); wait_done(1, "t1_lsl", 0);
    // test 2
    start_op(8'h90, 3, MODE_ASR, 8'hF2); wait_done(3, "t2_asr", 0);
    start_op(8'h90, 3, MODE_LSR, 8'h12); wait_done(3, "t2_lsr", 0);
    // test 3
    start_op(8'h81, 1, MODE_ROL, 8'h03); wait_done(1, "t3_rol", 0);
    start_op(8'hFF, 7, MODE_LSR, 8'h01); wait_done(7, "t3_lsr7", 0);
    start_op(8'h80, 1, MODE_LSL, 8'h00); wait_done(1, "t3_lsl_zero", 0);

    // test 4: amount 0 in each mode, then hold with init low
    for (int m = 0; m < 4; m++) begin
      start_op(8'h5A, 0, 2'(m), 8'h5A);
      wait_done(0, $sformatf("t4_amt0_m%0d", m), 0);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("t4_hold_out", 32'(bus.out), 32'h5A);
      check("t4_hold_done", 32'(bus.done), 32'd0);
    end

    // test 5: init mid-op and in FINISH ignored, then back-to-back accept
    start_op(8'h01, 6, MODE_LSL, 8'h40); wait_done(6, "t5_ignore", 1);
    start_op(8'hC0, 2, MODE_LSR, 8'h30); wait_done(2, "t5_next", 0);

    // random operations against the closed-form model
    for (int i = 0; i < 8; i++) begin
      rd = W'($urandom_range(0, 255));
      ra = $urandom_range(0, 7);
      rm = 2'($urandom_range(0, 3));
      start_op(rd, ra, rm, model(rd, ra, rm));
      wait_done(ra, $sformatf("rand%0d", i), 0);
    end

    // test 6: asynchronous reset mid-operation
    start_op(8'h80, 7, MODE_ASR, 8'hFF);
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("t6_async_out", 32'(bus.out), 32'h00);
    check("t6_async_busy", 32'(bus.busy), 32'd0);
    check("t6_async_done", 32'(bus.done), 32'd0);
    check("t6_async_zero", 32'(bus.zero), 32'd1);
    exp_q.delete();
    @(negedge clk);
    check("t6_rst_done", 32'(bus.done), 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("t6_no_done", 32'(bus.done), 32'd0);
    end
    start_op(8'h03, 2, MODE_LSL, 8'h0C); wait_done(2, "t6_fresh", 0);

    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_seq_shift_unit
